// File: rtl/tree_mem_pkg.sv
// tree_mem_pkg: shared constants, FSM state type and address-split helpers
// for the banked memory.
//   DEF_*        default parameter values for tree_banked_memory
//   mem_state_e  zeroing sweep (INIT) / normal operation (RUN)
//   split_row    word address -> row index (drop the bank-select bits)
//   split_bank   word address -> bank index (keep the bank-select bits)
package tree_mem_pkg;

  localparam int DEF_WORD_WIDTH  = 32;
  localparam int DEF_NUM_BANKS   = 4;
  localparam int DEF_DEPTH_WORDS = 2048;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } mem_state_e;

  // Banks are a power of two, so the split is a shift and a mask.
  function automatic logic [31:0] split_row(input logic [31:0] addr,
                                            input int unsigned bank_bits);
    return addr >> bank_bits;
  endfunction

  function automatic logic [31:0] split_bank(input logic [31:0] addr,
                                             input int unsigned bank_bits);
    return addr & ((32'd1 << bank_bits) - 32'd1);
  endfunction

endpackage

// File: rtl/tree_mem_bank.sv
// tree_mem_bank: simple dual-port, read-first RAM of ROWS words.
//   clk            clock
//   we1/addr1      port 1 write strobe / address (shared with port 1 read)
//   wdata1         port 1 write data
//   re1/rdata1     port 1 read enable / registered read data
//   re2/addr2      port 2 read enable / address
//   rdata2         port 2 registered read data
// A read of the row being written returns the old contents.
module tree_mem_bank #(
  parameter  int WORD_WIDTH = 32,
  parameter  int ROWS       = 512,
  localparam int RW         = $clog2(ROWS)
) (
  input  logic                  clk,
  input  logic                  we1,
  input  logic [RW-1:0]         addr1,
  input  logic [WORD_WIDTH-1:0] wdata1,
  input  logic                  re1,
  output logic [WORD_WIDTH-1:0] rdata1,
  input  logic                  re2,
  input  logic [RW-1:0]         addr2,
  output logic [WORD_WIDTH-1:0] rdata2
);

  logic [WORD_WIDTH-1:0] mem [ROWS];
  logic [WORD_WIDTH-1:0] rdata1_reg;
  logic [WORD_WIDTH-1:0] rdata2_reg;

  // Non-blocking write alongside the registered read gives read-first.
  always_ff @(posedge clk) begin
    if (we1) begin
      mem[addr1] <= wdata1;
    end
    if (re1) begin
      rdata1_reg <= mem[addr1];
    end
  end

  always_ff @(posedge clk) begin
    if (re2) begin
      rdata2_reg <= mem[addr2];
    end
  end

  assign rdata1 = rdata1_reg;
  assign rdata2 = rdata2_reg;

endmodule

// File: rtl/tree_banked_memory.sv
// tree_banked_memory: word-banked memory with a full-row write port, an
// unaligned wide read port and a single-word narrow read port.
//   clk, rst_n               clock, synchronous active-low reset
//   wr_en/wr_row/wr_data     write NUM_BANKS words (word i -> bank i) to a row
//   rda_valid/rda_ready      wide read handshake, rda_addr any word address
//   rda_data/rda_dvalid      NUM_BANKS words starting at rda_addr, 2 cycles later
//   rdb_valid/rdb_ready      narrow read handshake, rdb_addr word address
//   rdb_data/rdb_dvalid      single word at rdb_addr, 2 cycles later
//   init_done                high once the post-reset zeroing sweep finished
module tree_banked_memory
  import tree_mem_pkg::*;
#(
  parameter  int WORD_WIDTH  = DEF_WORD_WIDTH,
  parameter  int NUM_BANKS   = DEF_NUM_BANKS,
  parameter  int DEPTH_WORDS = DEF_DEPTH_WORDS,
  localparam int ROWS        = DEPTH_WORDS / NUM_BANKS,
  localparam int AW          = $clog2(DEPTH_WORDS),
  localparam int RW          = $clog2(ROWS)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            wr_en,
  input  logic [RW-1:0]                   wr_row,
  input  logic [NUM_BANKS*WORD_WIDTH-1:0] wr_data,
  input  logic                            rda_valid,
  output logic                            rda_ready,
  input  logic [AW-1:0]                   rda_addr,
  output logic [NUM_BANKS*WORD_WIDTH-1:0] rda_data,
  output logic                            rda_dvalid,
  input  logic                            rdb_valid,
  output logic                            rdb_ready,
  input  logic [AW-1:0]                   rdb_addr,
  output logic [WORD_WIDTH-1:0]           rdb_data,
  output logic                            rdb_dvalid,
  output logic                            init_done
);

  localparam int BW = $clog2(NUM_BANKS);

  mem_state_e                      state_reg;
  logic [RW-1:0]                   cnt_reg;
  logic                            init_done_reg;

  logic                            accept_a;
  logic                            accept_b;
  logic                            init_wr;
  logic                            user_wr;
  logic                            port1_we;

  logic [RW-1:0]                   a_row;
  logic [RW-1:0]                   a_row_next;
  logic [BW-1:0]                   a_off;
  logic [RW-1:0]                   b_row;
  logic [BW-1:0]                   b_bank;

  logic [BW-1:0]                   off_reg;
  logic [BW-1:0]                   bsel_reg;
  logic                            a_p1_reg;
  logic                            b_p1_reg;
  logic                            rda_dvalid_reg;
  logic                            rdb_dvalid_reg;
  logic [NUM_BANKS*WORD_WIDTH-1:0] rda_data_reg;
  logic [WORD_WIDTH-1:0]           rdb_data_reg;

  logic [WORD_WIDTH-1:0]           rdata1 [NUM_BANKS];
  logic [WORD_WIDTH-1:0]           rdata2 [NUM_BANKS];
  logic [NUM_BANKS*WORD_WIDTH-1:0] rot_flat;

  // Zeroing sweep: one row per cycle, then RUN forever (until reset).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= INIT;
      cnt_reg       <= '0;
      init_done_reg <= 1'b0;
    end else begin
      case (state_reg)
        INIT: begin
          if (cnt_reg == RW'(ROWS - 1)) begin
            state_reg     <= RUN;
            init_done_reg <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        RUN: begin
          init_done_reg <= 1'b1;
        end
      endcase
    end
  end

  assign init_done = init_done_reg;
  // Port 1 is shared by writes and wide reads, so a write blocks wide reads.
  assign rda_ready = init_done_reg && !wr_en;
  assign rdb_ready = init_done_reg;
  assign accept_a  = rda_valid && rda_ready;
  assign accept_b  = rdb_valid && rdb_ready;
  assign init_wr   = (state_reg == INIT);
  assign user_wr   = wr_en && init_done_reg;
  assign port1_we  = init_wr || user_wr;

  assign a_row      = RW'(split_row(32'(rda_addr), BW));
  assign a_off      = BW'(split_bank(32'(rda_addr), BW));
  assign a_row_next = (a_row == RW'(ROWS - 1)) ? '0 : a_row + 1'b1;
  assign b_row      = RW'(split_row(32'(rdb_addr), BW));
  assign b_bank     = BW'(split_bank(32'(rdb_addr), BW));

  for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
    logic [RW-1:0]         addr1;
    logic [WORD_WIDTH-1:0] wdata1;
    logic [BW-1:0]         lane_sel;

    // Banks below the start offset hold the words that spill into the next
    // row (wrapping past the last row back to row 0).
    always_comb begin
      addr1 = a_row;
      if (init_wr) begin
        addr1 = cnt_reg;
      end else if (user_wr) begin
        addr1 = wr_row;
      end else if (BW'(gi) < a_off) begin
        addr1 = a_row_next;
      end
    end

    assign wdata1 = init_wr ? '0 : wr_data[gi*WORD_WIDTH +: WORD_WIDTH];

    tree_mem_bank #(
      .WORD_WIDTH (WORD_WIDTH),
      .ROWS       (ROWS)
    ) u_bank (
      .clk    (clk),
      .we1    (port1_we),
      .addr1  (addr1),
      .wdata1 (wdata1),
      .re1    (accept_a),
      .rdata1 (rdata1[gi]),
      .re2    (accept_b),
      .addr2  (b_row),
      .rdata2 (rdata2[gi])
    );

    // Lane gi carries word (a + gi), which lives in bank (off + gi) mod NUM_BANKS;
    // the BW-bit sum wraps naturally.
    assign lane_sel = BW'(gi) + off_reg;
    assign rot_flat[gi*WORD_WIDTH +: WORD_WIDTH] = rdata1[lane_sel];
  end

  // Offset and bank select travel with the RAM read, so they update only
  // when the RAM output registers do.
  always_ff @(posedge clk) begin
    if (accept_a) begin
      off_reg <= a_off;
    end
    if (accept_b) begin
      bsel_reg <= b_bank;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_p1_reg       <= 1'b0;
      b_p1_reg       <= 1'b0;
      rda_dvalid_reg <= 1'b0;
      rdb_dvalid_reg <= 1'b0;
      rda_data_reg   <= '0;
      rdb_data_reg   <= '0;
    end else begin
      a_p1_reg       <= accept_a;
      b_p1_reg       <= accept_b;
      rda_dvalid_reg <= a_p1_reg;
      rdb_dvalid_reg <= b_p1_reg;
      if (a_p1_reg) begin
        rda_data_reg <= rot_flat;
      end
      if (b_p1_reg) begin
        rdb_data_reg <= rdata2[bsel_reg];
      end
    end
  end

  assign rda_data   = rda_data_reg;
  assign rda_dvalid = rda_dvalid_reg;
  assign rdb_data   = rdb_data_reg;
  assign rdb_dvalid = rdb_dvalid_reg;

endmodule

// File: tb/tb_tree_banked_memory.sv
// Testbench for tree_banked_memory at default parameters (4 banks x 512 rows).
module tb_tree_banked_memory;

  localparam int WW    = 32;
  localparam int NB    = 4;
  localparam int DEPTH = 2048;
  localparam int ROWS  = 512;
  localparam int AW    = 11;
  localparam int RW    = 9;

  logic             clk;
  logic             rst_n;
  logic             wr_en;
  logic [RW-1:0]    wr_row;
  logic [NB*WW-1:0] wr_data;
  logic             rda_valid;
  logic             rda_ready;
  logic [AW-1:0]    rda_addr;
  logic [NB*WW-1:0] rda_data;
  logic             rda_dvalid;
  logic             rdb_valid;
  logic             rdb_ready;
  logic [AW-1:0]    rdb_addr;
  logic [WW-1:0]    rdb_data;
  logic             rdb_dvalid;
  logic             init_done;

  typedef struct {
    logic [NB*WW-1:0] data;
    int               due;
  } exp_a_t;

  typedef struct {
    logic [WW-1:0] data;
    int            due;
  } exp_b_t;

  exp_a_t           qa[$];
  exp_b_t           qb[$];
  exp_a_t           ea;
  exp_b_t           eb;
  logic [WW-1:0]    model [DEPTH];
  logic [NB*WW-1:0] last_a;
  logic [WW-1:0]    last_b;
  int               checks = 0;
  int               errors = 0;
  int               cyc    = 0;

  tree_banked_memory dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_row     (wr_row),
    .wr_data    (wr_data),
    .rda_valid  (rda_valid),
    .rda_ready  (rda_ready),
    .rda_addr   (rda_addr),
    .rda_data   (rda_data),
    .rda_dvalid (rda_dvalid),
    .rdb_valid  (rdb_valid),
    .rdb_ready  (rdb_ready),
    .rdb_addr   (rdb_addr),
    .rdb_data   (rdb_data),
    .rdb_dvalid (rdb_dvalid),
    .init_done  (init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1, "watchdog");
  end

  // Scoreboard: pop one expected entry per dvalid and check data and arrival cycle.
  always @(negedge clk) begin
    if (qa.size() != 0 && qa[0].due < cyc) begin
      checks++;
      errors++;
      ea = qa.pop_front();
      $display("FAIL rda_missing: no dvalid at cycle %0d, required data %h", ea.due, ea.data);
    end
    if (rda_dvalid === 1'b1) begin
      checks++;
      if (qa.size() == 0) begin
        errors++;
        $display("FAIL rda_unexpected: dvalid with data %h at cycle %0d, required no dvalid", rda_data, cyc);
      end else begin
        ea = qa.pop_front();
        if (rda_data !== ea.data || cyc != ea.due) begin
          errors++;
          $display("FAIL rda_result: got %h at cycle %0d, required %h at cycle %0d", rda_data, cyc, ea.data, ea.due);
        end else begin
          $display("rda read ok: data %h cycle %0d", rda_data, cyc);
        end
      end
      last_a = rda_data;
    end
    if (qb.size() != 0 && qb[0].due < cyc) begin
      checks++;
      errors++;
      eb = qb.pop_front();
      $display("FAIL rdb_missing: no dvalid at cycle %0d, required data %h", eb.due, eb.data);
    end
    if (rdb_dvalid === 1'b1) begin
      checks++;
      if (qb.size() == 0) begin
        errors++;
        $display("FAIL rdb_unexpected: dvalid with data %h at cycle %0d, required no dvalid", rdb_data, cyc);
      end else begin
        eb = qb.pop_front();
        if (rdb_data !== eb.data || cyc != eb.due) begin
          errors++;
          $display("FAIL rdb_result: got %h at cycle %0d, required %h at cycle %0d", rdb_data, cyc, eb.data, eb.due);
        end else begin
          $display("rdb read ok: data %h cycle %0d", rdb_data, cyc);
        end
      end
      last_b = rdb_data;
    end
  end

  function automatic logic [NB*WW-1:0] exp_wide(input int a);
    logic [NB*WW-1:0] r;
    for (int i = 0; i < NB; i++) begin
      r[i*WW +: WW] = model[(a + i) % DEPTH];
    end
    return r;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < DEPTH; i++) begin
      model[i] = '0;
    end
  endtask

  task automatic model_write(input int row, input logic [NB*WW-1:0] data);
    for (int i = 0; i < NB; i++) begin
      model[row*NB + i] = data[i*WW +: WW];
    end
  endtask

  // Called at a negedge; drives the request and, if accepted, records the result due 2 edges later.
  task automatic wide_read(input int addr, input logic push);
    rda_valid = 1'b1;
    rda_addr  = AW'(addr);
    #1;
    checks++;
    if (rda_ready !== 1'b1) begin
      errors++;
      $display("FAIL rda_ready_accept: got %b, required 1 (addr %0d)", rda_ready, addr);
    end else if (push) begin
      qa.push_back('{data: exp_wide(addr), due: cyc + 2});
    end
  endtask

  task automatic narrow_read(input int addr);
    rdb_valid = 1'b1;
    rdb_addr  = AW'(addr);
    #1;
    checks++;
    if (rdb_ready !== 1'b1) begin
      errors++;
      $display("FAIL rdb_ready_accept: got %b, required 1 (addr %0d)", rdb_ready, addr);
    end else begin
      qb.push_back('{data: model[addr], due: cyc + 2});
    end
  endtask

  task automatic drive_write(input int row, input logic [NB*WW-1:0] data);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_row  = RW'(row);
    wr_data = data;
    model_write(row, data);
    $display("write row %0d data %h", row, data);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic end_reads();
    @(negedge clk);
    rda_valid = 1'b0;
    rdb_valid = 1'b0;
  endtask

  // Counts edges from rst_n release until init_done is seen high.
  task automatic wait_init(output int n);
    n = 0;
    while (init_done !== 1'b1 && n < 2000) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    int n;
    rst_n     = 1'b0;
    wr_en     = 1'b0;
    wr_row    = '0;
    wr_data   = '0;
    rda_valid = 1'b0;
    rda_addr  = '0;
    rdb_valid = 1'b0;
    rdb_addr  = '0;
    repeat (3) @(negedge clk);
    checks += 3;
    if (init_done !== 1'b0) begin errors++; $display("FAIL reset_init_done: got %b, required 0", init_done); end
    if (rda_dvalid !== 1'b0 || rdb_dvalid !== 1'b0) begin
      errors++;
      $display("FAIL reset_dvalid: got a=%b b=%b, required 0 0", rda_dvalid, rdb_dvalid);
    end
    if (rda_data !== '0 || rdb_data !== '0) begin
      errors++;
      $display("FAIL reset_data: got a=%h b=%h, required zeros", rda_data, rdb_data);
    end
    clear_model();
    rst_n     = 1'b1;
    rda_valid = 1'b1;
    rda_addr  = AW'(5);
    n = 0;
    while (init_done !== 1'b1 && n < 2000) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      // Writes attempted during zeroing must be dropped (row 0 is already swept).
      if (n >= 500 && n < 506) begin
        wr_en   = 1'b1;
        wr_row  = '0;
        wr_data = '1;
      end else begin
        wr_en = 1'b0;
      end
    end
    wr_en = 1'b0;
    checks++;
    if (n != ROWS) begin
      errors++;
      $display("FAIL init_latency: got %0d cycles, required %0d", n, ROWS);
    end
    $display("init_done after %0d cycles", n);
    wide_read(5, 1'b1);
    end_reads();
    @(negedge clk);
    narrow_read(0);
    end_reads();
    repeat (3) @(negedge clk);
  endtask

  task automatic test_wide_write();
    drive_write(0, {32'h03, 32'h02, 32'h01, 32'h00});
    drive_write(1, {32'h13, 32'h12, 32'h11, 32'h10});
    @(negedge clk);
    wide_read(2, 1'b1);
    end_reads();
    repeat (3) @(negedge clk);
    checks += 2;
    if (last_a !== {32'h11, 32'h10, 32'h03, 32'h02}) begin
      errors++;
      $display("FAIL wide_unaligned: got %h, required %h", last_a, {32'h11, 32'h10, 32'h03, 32'h02});
    end
    if (rda_dvalid !== 1'b0 || rda_data !== {32'h11, 32'h10, 32'h03, 32'h02}) begin
      errors++;
      $display("FAIL wide_hold: got dvalid=%b data=%h, required 0 and held %h", rda_dvalid, rda_data,
               {32'h11, 32'h10, 32'h03, 32'h02});
    end
    drive_write(511, {32'hF3, 32'hF2, 32'hF1, 32'hF0});
    @(negedge clk);
    wide_read(2046, 1'b1);
    end_reads();
    repeat (3) @(negedge clk);
    checks++;
    if (last_a !== {32'h01, 32'h00, 32'hF3, 32'hF2}) begin
      errors++;
      $display("FAIL wide_wrap: got %h, required %h", last_a, {32'h01, 32'h00, 32'hF3, 32'hF2});
    end
  endtask

  task automatic test_read_first();
    @(negedge clk);
    wr_en   = 1'b1;
    wr_row  = RW'(1);
    wr_data = {32'h23, 32'h22, 32'h21, 32'h20};
    narrow_read(7);                 // records the old word 0x13
    model_write(1, {32'h23, 32'h22, 32'h21, 32'h20});
    @(negedge clk);
    wr_en = 1'b0;
    narrow_read(7);                 // records the new word 0x23
    end_reads();
    repeat (3) @(negedge clk);
    checks++;
    if (last_b !== 32'h23) begin
      errors++;
      $display("FAIL read_first_next: got %h, required 00000023", last_b);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    wr_en     = 1'b1;
    wr_row    = RW'(2);
    wr_data   = {32'h33, 32'h32, 32'h31, 32'h30};
    rda_valid = 1'b1;
    rda_addr  = AW'(0);
    #1;
    checks++;
    if (rda_ready !== 1'b0) begin
      errors++;
      $display("FAIL write_blocks_read: rda_ready got %b, required 0", rda_ready);
    end
    model_write(2, {32'h33, 32'h32, 32'h31, 32'h30});
    @(negedge clk);
    wr_en = 1'b0;
    wide_read(0, 1'b1);
    @(negedge clk);
    wide_read(1, 1'b1);
    @(negedge clk);
    wide_read(2, 1'b1);
    end_reads();
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_midop();
    int n;
    @(negedge clk);
    wide_read(4, 1'b0);             // accepted, then discarded by reset
    @(negedge clk);
    rda_valid = 1'b0;
    rst_n     = 1'b0;
    @(negedge clk);
    checks += 2;
    if (rda_dvalid !== 1'b0 || init_done !== 1'b0) begin
      errors++;
      $display("FAIL midop_reset: got dvalid=%b init_done=%b, required 0 0", rda_dvalid, init_done);
    end
    if (rda_data !== '0) begin
      errors++;
      $display("FAIL midop_reset_data: got %h, required zeros", rda_data);
    end
    @(negedge clk);
    clear_model();
    rst_n = 1'b1;
    wait_init(n);
    checks++;
    if (n != ROWS) begin
      errors++;
      $display("FAIL reinit_latency: got %0d cycles, required %0d", n, ROWS);
    end
    wide_read(4, 1'b1);
    end_reads();
    @(negedge clk);
    narrow_read(1);
    end_reads();
    repeat (4) @(negedge clk);
    checks++;
    if (last_a !== '0) begin
      errors++;
      $display("FAIL reinit_zero: got %h, required zeros", last_a);
    end
  endtask

  initial begin
    test_reset();
    test_wide_write();
    test_read_first();
    test_back_to_back();
    test_reset_midop();
    checks++;
    if (qa.size() != 0 || qb.size() != 0) begin
      errors++;
      $display("FAIL pending_results: got %0d/%0d outstanding, required 0/0", qa.size(), qb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
